// File: rtl/ysyx_041461_clint_pkg.sv
// Shared CLINT definitions: register map, AXI response codes, FSM encodings
// and the byte-strobe merge used by register writes.
package ysyx_041461_clint_pkg;

    localparam logic [31:0] MTIMECMP_ADDR = 32'h0200_4000;
    localparam logic [31:0] MTIME_ADDR    = 32'h0200_bff8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    function automatic logic [63:0] strb_merge(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        for (int i = 0; i < 8; i++)
            res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/ysyx_041461_clint_if.sv
// AXI4 single-beat bus as seen by the CLINT; master drives requests, slave
// drives ready/response signals.
interface ysyx_041461_clint_if;
    logic        awvalid;
    logic        awready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        bvalid;
    logic        bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic [63:0] rdata;
    logic        rlast;

    modport master (
        output awvalid, awid, awaddr, wvalid, wdata, wstrb, wlast, bready,
               arvalid, arid, araddr, rready,
        input  awready, wready, bvalid, bid, bresp,
               arready, rvalid, rid, rresp, rdata, rlast
    );

    modport slave (
        input  awvalid, awid, awaddr, wvalid, wdata, wstrb, wlast, bready,
               arvalid, arid, araddr, rready,
        output awready, wready, bvalid, bid, bresp,
               arready, rvalid, rid, rresp, rdata, rlast
    );
endinterface

// File: rtl/ysyx_041461_clint_timer.sv
// mtime/mtimecmp storage, the mtime prescaler and the registered timer
// interrupt compare.
module ysyx_041461_clint_timer #(
    parameter int MTIME_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mtime_we,
    input  logic        i_mtimecmp_we,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_mtime,
    output logic [63:0] o_mtimecmp,
    output logic        o_mtip
);
    localparam logic [7:0] DIV_LAST = 8'(MTIME_DIV - 1);

    logic [7:0]  r_pre;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_mtip;
    logic        w_tick;

    assign w_tick = (r_pre == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre      <= 8'd0;
            r_mtime    <= 64'd0;
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_mtip     <= 1'b0;
        end else begin
            r_pre <= w_tick ? 8'd0 : r_pre + 8'd1;
            // A software write wins over the tick; the written value is kept as-is.
            if (i_mtime_we)
                r_mtime <= i_wdata;
            else if (w_tick)
                r_mtime <= r_mtime + 64'd1;
            if (i_mtimecmp_we)
                r_mtimecmp <= i_wdata;
            r_mtip <= (r_mtime >= r_mtimecmp);
        end
    end

    assign o_mtime    = r_mtime;
    assign o_mtimecmp = r_mtimecmp;
    assign o_mtip     = r_mtip;
endmodule

// File: rtl/ysyx_041461_clint.sv
// CLINT top: independent AXI write and read FSMs in front of the timer block.
module ysyx_041461_clint
    import ysyx_041461_clint_pkg::*;
#(
    parameter int MTIME_DIV = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    ysyx_041461_clint_if.slave   s_axi,
    output logic                 mtip
);
    wstate_t     r_wstate, w_wstate_nxt;
    rstate_t     r_rstate, w_rstate_nxt;
    logic [3:0]  r_awid;
    logic [28:0] r_awaddr;
    logic [1:0]  r_bresp;
    logic [3:0]  r_rid;
    logic [1:0]  r_rresp;
    logic [63:0] r_rdata;

    logic [63:0] w_mtime, w_mtimecmp, w_wdata_m;
    logic        w_wfire, w_whit_mtime, w_whit_cmp;
    logic        w_rfire, w_rhit_mtime, w_rhit_cmp;
    logic        w_unused;

    assign w_unused = ^{s_axi.wlast, s_axi.awaddr[2:0], s_axi.araddr[2:0]};

    // ---------------- write channel ----------------
    assign w_wfire      = (r_wstate == W_DATA) && s_axi.wvalid;
    assign w_whit_mtime = (r_awaddr == MTIME_ADDR[31:3]);
    assign w_whit_cmp   = (r_awaddr == MTIMECMP_ADDR[31:3]);
    assign w_wdata_m    = strb_merge(w_whit_mtime ? w_mtime : w_mtimecmp,
                                     s_axi.wdata, s_axi.wstrb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_wstate <= W_IDLE;
        else     r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (s_axi.awvalid) w_wstate_nxt = W_DATA;
            W_DATA:  if (s_axi.wvalid)  w_wstate_nxt = W_RESP;
            W_RESP:  if (s_axi.bready)  w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_awid   <= 4'd0;
            r_awaddr <= 29'd0;
            r_bresp  <= RESP_OKAY;
        end else begin
            if (r_wstate == W_IDLE && s_axi.awvalid) begin
                r_awid   <= s_axi.awid;
                r_awaddr <= s_axi.awaddr[31:3];
            end
            if (w_wfire)
                r_bresp <= (w_whit_mtime || w_whit_cmp) ? RESP_OKAY : RESP_DECERR;
        end
    end

    assign s_axi.awready = (r_wstate == W_IDLE);
    assign s_axi.wready  = (r_wstate == W_DATA);
    assign s_axi.bvalid  = (r_wstate == W_RESP);
    assign s_axi.bid     = r_awid;
    assign s_axi.bresp   = r_bresp;

    // ---------------- read channel ----------------
    assign w_rfire      = (r_rstate == R_IDLE) && s_axi.arvalid;
    assign w_rhit_mtime = (s_axi.araddr[31:3] == MTIME_ADDR[31:3]);
    assign w_rhit_cmp   = (s_axi.araddr[31:3] == MTIMECMP_ADDR[31:3]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rstate <= R_IDLE;
        else     r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (s_axi.arvalid) w_rstate_nxt = R_DATA;
            R_DATA:  if (s_axi.rready)  w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Capture samples registers before this edge's update, so a colliding write is not seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rid   <= 4'd0;
            r_rresp <= RESP_OKAY;
            r_rdata <= 64'd0;
        end else if (w_rfire) begin
            r_rid <= s_axi.arid;
            if (w_rhit_mtime) begin
                r_rdata <= w_mtime;
                r_rresp <= RESP_OKAY;
            end else if (w_rhit_cmp) begin
                r_rdata <= w_mtimecmp;
                r_rresp <= RESP_OKAY;
            end else begin
                r_rdata <= 64'd0;
                r_rresp <= RESP_DECERR;
            end
        end
    end

    assign s_axi.arready = (r_rstate == R_IDLE);
    assign s_axi.rvalid  = (r_rstate == R_DATA);
    assign s_axi.rlast   = (r_rstate == R_DATA);
    assign s_axi.rid     = r_rid;
    assign s_axi.rresp   = r_rresp;
    assign s_axi.rdata   = r_rdata;

    ysyx_041461_clint_timer #(.MTIME_DIV(MTIME_DIV)) u_timer (
        .clk           (clk),
        .rst           (rst),
        .i_mtime_we    (w_wfire && w_whit_mtime),
        .i_mtimecmp_we (w_wfire && w_whit_cmp),
        .i_wdata       (w_wdata_m),
        .o_mtime       (w_mtime),
        .o_mtimecmp    (w_mtimecmp),
        .o_mtip        (mtip)
    );
endmodule

// File: tb/tb_ysyx_041461_clint.sv
// Directed bench for the CLINT: reset, mtime counting, mtip, strobed writes,
// read/write collision, decode errors, read back-pressure and mid-write reset.
module tb_ysyx_041461_clint;
    localparam logic [31:0] A_MTIME = 32'h0200_bff8;
    localparam logic [31:0] A_CMP   = 32'h0200_4000;
    localparam logic [31:0] A_BAD   = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst;
    logic mtip;
    int   errors = 0;
    int   checks = 0;

    ysyx_041461_clint_if bus();

    ysyx_041461_clint #(.MTIME_DIV(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .s_axi (bus),
        .mtip  (mtip)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_phase(input logic [31:0] a, input logic [3:0] id);
        int n = 0;
        bus.awaddr = a; bus.awid = id; bus.awvalid = 1'b1;
        while (bus.awready !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if (n >= 20) begin errors++; $display("FAIL aw_timeout: awready stayed %b, want 1", bus.awready); end
        step();
        bus.awvalid = 1'b0;
    endtask

    task automatic w_phase(input logic [63:0] d, input logic [7:0] s);
        int n = 0;
        bus.wdata = d; bus.wstrb = s; bus.wlast = 1'b1; bus.wvalid = 1'b1;
        while (bus.wready !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if (n >= 20) begin errors++; $display("FAIL w_timeout: wready stayed %b, want 1", bus.wready); end
        step();
        bus.wvalid = 1'b0;
    endtask

    task automatic b_phase(output logic [1:0] resp, output logic [3:0] id);
        int n = 0;
        bus.bready = 1'b1;
        while (bus.bvalid !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if (n >= 20) begin errors++; $display("FAIL b_timeout: bvalid stayed %b, want 1", bus.bvalid); end
        resp = bus.bresp; id = bus.bid;
        step();
        bus.bready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [3:0] id, output logic [63:0] d,
                      output logic [1:0] resp, output logic [3:0] rid, output logic last);
        int n = 0;
        bus.araddr = a; bus.arid = id; bus.arvalid = 1'b1;
        while (bus.arready !== 1'b1 && n < 20) begin step(); n++; end
        step();
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        n = 0;
        while (bus.rvalid !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if (n >= 20) begin errors++; $display("FAIL r_timeout: rvalid stayed %b, want 1", bus.rvalid); end
        d = bus.rdata; resp = bus.rresp; rid = bus.rid; last = bus.rlast;
        step();
        bus.rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0;
        bus.wstrb = 0; bus.wlast = 1; bus.bready = 0; bus.arvalid = 0; bus.arid = 0;
        bus.araddr = 0; bus.rready = 0;
        repeat (3) step();
        rst = 1'b0;
        checks++;
        if ({bus.bvalid, bus.rvalid, bus.rlast, mtip} !== 4'b0000) begin
            errors++; $display("FAIL reset_valids: bvalid/rvalid/rlast/mtip=%b want 0000",
                               {bus.bvalid, bus.rvalid, bus.rlast, mtip});
        end
        checks++;
        if ({bus.awready, bus.arready, bus.wready} !== 3'b110) begin
            errors++; $display("FAIL reset_ready: awready/arready/wready=%b want 110",
                               {bus.awready, bus.arready, bus.wready});
        end
        checks++;
        if ({bus.rid, bus.bid, bus.rresp, bus.bresp, bus.rdata} !== 76'd0) begin
            errors++; $display("FAIL reset_outs: rid=%h bid=%h rresp=%b bresp=%b rdata=%h want all 0",
                               bus.rid, bus.bid, bus.rresp, bus.bresp, bus.rdata);
        end
    endtask

    task automatic test_mtime_count();
        logic [63:0] d; logic [1:0] r; logic [3:0] id; logic l;
        repeat (10) step();
        rd(A_MTIME, 4'h5, d, r, id, l);
        checks++;
        if (d < 64'd8 || d > 64'd12) begin
            errors++; $display("FAIL mtime_count: got %0d want 10+-2", d);
        end
        checks++;
        if ({r, l, id} !== {2'b00, 1'b1, 4'h5}) begin
            errors++; $display("FAIL mtime_rd_meta: rresp=%b rlast=%b rid=%h want 00 1 5", r, l, id);
        end
    endtask

    task automatic test_mtip();
        logic [1:0] r; logic [3:0] id; int n;
        aw_phase(A_CMP, 4'h3);
        w_phase(64'd5, 8'hFF);
        b_phase(r, id);
        checks++;
        if ({r, id} !== {2'b00, 4'h3}) begin
            errors++; $display("FAIL cmp_bresp: bresp=%b bid=%h want 00 3", r, id);
        end
        checks++;
        if (mtip !== 1'b1) begin errors++; $display("FAIL mtip_past: got %b want 1", mtip); end
        aw_phase(A_MTIME, 4'h1);
        w_phase(64'd0, 8'hFF);
        for (n = 1; n <= 20; n++) begin
            step();
            if (n == 2) begin
                checks++;
                if (mtip !== 1'b0) begin errors++; $display("FAIL mtip_low: got %b want 0", mtip); end
            end
            if (mtip === 1'b1) break;
        end
        checks++;
        if (n != 6) begin errors++; $display("FAIL mtip_rise: rose after %0d cycles want 6", n); end
        b_phase(r, id);
    endtask

    task automatic test_partial_write();
        logic [63:0] d; logic [1:0] r; logic [3:0] id; logic l;
        aw_phase(A_MTIME, 4'h2);
        w_phase(64'hAAAA_BBBB_0000_0030, 8'hFF);
        b_phase(r, id);
        aw_phase(A_MTIME + 32'd4, 4'h2);
        w_phase(64'h1111_1111_2222_2222, 8'h0F);
        rd(A_MTIME, 4'h8, d, r, id, l);
        checks++;
        if (d !== 64'hAAAA_BBBB_2222_2222) begin
            errors++; $display("FAIL strb_merge: got %h want aaaabbbb22222222", d);
        end
        b_phase(r, id);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL strb_bresp: got %b want 00", r); end
    endtask

    task automatic test_same_cycle();
        logic [63:0] d; logic [1:0] r; logic [3:0] id; logic l;
        aw_phase(A_CMP, 4'h6);
        bus.wdata = 64'h77; bus.wstrb = 8'hFF; bus.wvalid = 1'b1;
        bus.araddr = A_CMP; bus.arid = 4'h9; bus.arvalid = 1'b1;
        step();
        bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        checks++;
        if ({bus.rvalid, bus.rdata, bus.rid} !== {1'b1, 64'd5, 4'h9}) begin
            errors++; $display("FAIL collide_rd: rvalid=%b rdata=%h rid=%h want 1 5 9",
                               bus.rvalid, bus.rdata, bus.rid);
        end
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        b_phase(r, id);
        checks++;
        if (id !== 4'h6) begin errors++; $display("FAIL collide_bid: got %h want 6", id); end
        rd(A_CMP, 4'h1, d, r, id, l);
        checks++;
        if (d !== 64'h77) begin errors++; $display("FAIL collide_after: got %h want 77", d); end
    endtask

    task automatic test_decerr();
        logic [63:0] d; logic [1:0] r; logic [3:0] id; logic l;
        rd(A_BAD, 4'hC, d, r, id, l);
        checks++;
        if ({d, r, id, l} !== {64'd0, 2'b11, 4'hC, 1'b1}) begin
            errors++; $display("FAIL dec_rd: rdata=%h rresp=%b rid=%h rlast=%b want 0 11 c 1", d, r, id, l);
        end
        aw_phase(A_BAD, 4'hD);
        w_phase(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        b_phase(r, id);
        checks++;
        if ({r, id} !== {2'b11, 4'hD}) begin
            errors++; $display("FAIL dec_wr: bresp=%b bid=%h want 11 d", r, id);
        end
        rd(A_CMP, 4'h2, d, r, id, l);
        checks++;
        if (d !== 64'h77) begin errors++; $display("FAIL dec_nochange: got %h want 77", d); end
    endtask

    task automatic test_rready_hold();
        bus.araddr = A_CMP; bus.arid = 4'hA; bus.arvalid = 1'b1; bus.rready = 1'b0;
        step();
        bus.arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.rvalid, bus.rdata, bus.rid} !== {1'b1, 64'h77, 4'hA}) begin
                errors++; $display("FAIL hold_%0d: rvalid=%b rdata=%h rid=%h want 1 77 a",
                                   i, bus.rvalid, bus.rdata, bus.rid);
            end
            step();
        end
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        checks++;
        if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL hold_done: rvalid=%b want 0", bus.rvalid); end
    endtask

    task automatic test_reset_mid_write();
        logic [63:0] d; logic [1:0] r; logic [3:0] id; logic l; int seen = 0;
        aw_phase(A_CMP, 4'h7);
        bus.bready = 1'b1;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.bvalid !== 1'b0) seen++;
            step();
        end
        bus.bready = 1'b0;
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_bvalid: bvalid high %0d cycles want 0", seen); end
        checks++;
        if ({bus.awready, bus.wready} !== 2'b10) begin
            errors++; $display("FAIL rst_ready: awready/wready=%b want 10", {bus.awready, bus.wready});
        end
        rd(A_CMP, 4'h3, d, r, id, l);
        checks++;
        if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL rst_cmp: got %h want all ones", d); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mtime_count();
        test_mtip();
        test_partial_write();
        test_same_cycle();
        test_decerr();
        test_rready_hold();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_041461_clint.md
YSYX_041461_CLINT -- requirements
Module: ysyx_041461_clint

Interface
REQ-001 SHALL have parameter MTIME_DIV, default 1, cycles of clk per mtime increment (legal range 1..255).
REQ-002 SHALL have ports as follows (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- awid  in  4  write transaction id
- awaddr  in  32  write address
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- wdata  in  64  write data
- wstrb  in  8  byte strobes
- wlast  in  1  last beat (always 1, ignored)
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- bid  out  4  response id
- bresp  out  2  write response
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- arid  in  4  read transaction id
- araddr  in  32  read address
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rid  out  4  read id
- rresp  out  2  read response
- rdata  out  64  read data
- rlast  out  1  last beat
- mtip  out  1  machine timer interrupt pending

Function
REQ-003 SHALL hold 64-bit mtime (0x0200_bff8..0x0200_bfff) and 64-bit mtimecmp (0x0200_4000..0x0200_4007); decode uses addr[31:3], so any byte offset within a register hits it.
REQ-004 SHALL run an 8-bit prescaler counting 0..MTIME_DIV-1, wrapping to 0; mtime increments by 1 (mod 2^64) on each wrap cycle.
REQ-005 SHALL register mtip each cycle as (mtime >= mtimecmp), unsigned compare; one cycle latency after any register change.
REQ-006 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE, wready=1 only in W_DATA, bvalid=1 only in W_RESP.
REQ-007 W_IDLE->W_DATA on awvalid&awready, latching awid and awaddr; W_DATA->W_RESP on wvalid, applying a per-byte merge of wdata under wstrb; W_RESP->W_IDLE on bready.
REQ-008 bid SHALL equal the latched awid; bresp SHALL be OKAY (00) for a decoded address and DECERR (11) otherwise; an undecoded write changes no state.
REQ-009 A write to mtime SHALL take priority over the increment in the same cycle; the written value is stored without +1.
REQ-010 Read FSM SHALL have states R_IDLE and R_DATA; arready=1 only in R_IDLE; R_IDLE->R_DATA on arvalid, capturing the full 64-bit register value, arid and the response into output registers.
REQ-011 In R_DATA: rvalid=1, rlast=1, rid=captured arid, rresp OKAY or DECERR (rdata=0 on DECERR); R_DATA->R_IDLE on rready; outputs SHALL stay stable while rready=0.
REQ-012 Read and write FSMs SHALL be independent; a read captured in the same cycle as a write to the same register SHALL return the pre-write value.
REQ-013 Throughput: one transaction per channel per 3 cycles (write) and 2 cycles (read) with ready/valid held high.

Reset
REQ-014 On rst: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0, mtip=0, both FSMs idle; bvalid=rvalid=0; awready=arready=1 from the first cycle after release; rid/bid/rresp/bresp/rdata=0, rlast=0.
REQ-015 Reset mid-transaction SHALL abandon it with no response issued.

Structure
REQ-016 Address constants, FSM state encodings and OKAY/DECERR encodings SHALL live in the shared ysyx_041461 defines package.
REQ-017 The mtime/prescaler/compare logic SHALL be one sub-module, ysyx_041461_clint_timer; the AXI FSMs stay in the top.

Verification
REQ-018 MTIME_DIV=1, no writes, 10 cycles after reset -> read 0x0200_bff8 returns 10±2, rresp 00, rlast 1, rid equals arid.
REQ-019 Write mtimecmp=5, wstrb=FF -> bresp 00; mtip rises within 1 cycle of mtime reaching 5.
REQ-020 Write mtime with wstrb=0x0F, wdata=0x1111_1111_2222_2222 when mtime=0x30 -> low word 0x2222_2222, upper word unchanged, no increment in the write cycle.
REQ-021 Read 0x1000_0000 -> rresp 11, rdata 0; write to the same address -> bresp 11, registers unchanged.
REQ-022 Hold rready=0 for 5 cycles -> rvalid and rdata stable; then assert rst mid-write in W_DATA -> bvalid never asserted, awready=1 after release.
